logic_unit_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one registered 3-input logic unit among NREQ requesters.
//  - Unit function: Dout <= f(A,B,C) = A | ~(B ^ C), with 1-cycle latency and no reset.
//  - Arbitrates requests, drives the unit operands, captures the unit result and returns it with the requester ID.
//  - Optional self-check of every captured result against an internal golden f.

---
 rtl/logic_unit_rr_sched.sv | 142 ++++++++++++++
 tb/tb_logic_unit_rr_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_rr_sched.sv
// Round-robin scheduler sharing one registered 3-input logic unit.
// Unit computes A | ~(B ^ C); one operation in flight at a time.
module logic_unit_rr_sched #(
    parameter int NREQ     = 4,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [3*NREQ-1:0]        req_opnd,
    output logic [NREQ-1:0]          req_ready,
    output logic                     unit_a,
    output logic                     unit_b,
    output logic                     unit_c,
    input  logic                     unit_dout,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_data,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic                     busy,
    output logic                     err
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] win;
    logic [IDW:0]   cand;
    logic           found;
    logic           grant;
    logic [2:0]     sel;
    logic [IDW-1:0] id;
    logic           golden;

    // Winner search: first asserted request starting at ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    // Operand bundle of the winner and the pointer value after its grant
    always_comb begin
        sel     = req_opnd[3*win +: 3];
        ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end

    // Next-state logic; grant only fires from IDLE
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant, operand issue, result capture and sticky self-check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= '0;
            unit_a     <= 1'b0;
            unit_b     <= 1'b0;
            unit_c     <= 1'b0;
            id         <= '0;
            golden     <= 1'b0;
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= 1'b0;
            resp_id    <= '0;
            err        <= 1'b0;
        end else begin
            req_ready <= '0;
            if (grant) begin
                req_ready <= NREQ'(1) << win;
                unit_a    <= sel[2];
                unit_b    <= sel[1];
                unit_c    <= sel[0];
                id        <= win;
                golden    <= sel[2] | ~(sel[1] ^ sel[0]);
                ptr       <= ptr_nxt;
            end
            if (state == WAIT) begin
                resp_data  <= unit_dout;
                resp_id    <= id;
                resp_valid <= 1'b1;
                if (CHECK_EN && (unit_dout != golden)) begin
                    err <= 1'b1;
                end
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Busy whenever an operation is in flight
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_logic_unit_rr_sched.sv
// Bench for logic_unit_rr_sched: transaction-level model plus
// literal pins for truth table, rr order, backpressure and err.
module tb_logic_unit_rr_sched;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [3*N-1:0] req_opnd = '0;
    logic [N-1:0]   req_ready;
    logic           unit_a;
    logic           unit_b;
    logic           unit_c;
    logic           unit_dout = 1'b0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic           resp_data;
    logic [IDW-1:0] resp_id;
    logic           busy;
    logic           err;

    logic_unit_rr_sched #(.NREQ(N), .CHECK_EN(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_opnd(req_opnd),
        .req_ready(req_ready),
        .unit_a(unit_a),
        .unit_b(unit_b),
        .unit_c(unit_c),
        .unit_dout(unit_dout),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_id(resp_id),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    // Shared logic unit, optionally corrupted to exercise the self-check
    logic corrupt = 1'b0;
    always @(posedge clk) begin
        unit_dout <= corrupt ? 1'b0 : (unit_a | ~(unit_b ^ unit_c));
    end

    int tests = 0;
    int fails = 0;

    logic [2:0] q [N][$];
    int         gnt_log [$];
    logic       rsp_log [$];
    int         cyc = 0;
    int         gnt_cyc = 0;
    logic       prev_rv = 1'b0;

    // Transaction-level model
    bit         m_pend = 0;
    int         m_age = 0;
    int         m_id = 0;
    logic       m_data = 1'b0;
    bit         m_bad = 0;
    int         m_ptr = 0;
    logic       m_err = 1'b0;
    logic [2:0] m_opnd = 3'b000;

    function automatic logic f3(input logic [2:0] o);
        return o[2] | ~(o[1] ^ o[0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] rv;
        logic [2:0]   ops [N];
        logic         shown;
        logic         rr;
        int           exp_g;
        int           idx;
        for (int i = 0; i < N; i++) begin
            rv[i]  = (q[i].size() != 0);
            ops[i] = rv[i] ? q[i][0] : 3'($urandom);
            req_opnd[3*i +: 3] = ops[i];
        end
        req_valid = rv;
        rr        = resp_ready;
        shown     = m_pend && (m_age >= 2);
        exp_g     = -1;
        @(posedge clk);
        #1;
        cyc++;
        if (!m_pend) begin
            if (rv != '0) begin
                idx = -1;
                for (int k = 0; k < N; k++) begin
                    if (idx < 0 && rv[(m_ptr + k) % N]) begin
                        idx = (m_ptr + k) % N;
                    end
                end
                exp_g  = idx;
                m_pend = 1;
                m_age  = 0;
                m_id   = idx;
                m_opnd = ops[idx];
                m_bad  = corrupt && f3(ops[idx]);
                m_data = corrupt ? 1'b0 : f3(ops[idx]);
                m_ptr  = (idx + 1) % N;
            end
        end else if (shown && rr) begin
            m_pend = 0;
        end else begin
            m_age++;
            if (m_age == 2 && m_bad) begin
                m_err = 1'b1;
            end
        end
        chk("req_ready", 32'(req_ready),
            (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("resp_valid", 32'(resp_valid), 32'(m_pend && m_age >= 2));
        if (m_pend && m_age >= 2) begin
            chk("resp_data", 32'(resp_data), 32'(m_data));
            chk("resp_id", 32'(resp_id), 32'(m_id));
        end
        chk("unit_opnd", 32'({unit_a, unit_b, unit_c}), 32'(m_opnd));
        chk("err", 32'(err), 32'(m_err));
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                gnt_log.push_back(i);
                gnt_cyc = cyc;
                if (q[i].size() != 0) begin
                    void'(q[i].pop_front());
                end
            end
        end
        if (resp_valid && !prev_rv) begin
            chk("latency", 32'(cyc - gnt_cyc + 1), 32'd3);
            rsp_log.push_back(resp_data);
        end
        prev_rv = resp_valid;
    endtask

    function automatic bit pending_work();
        bit w;
        w = m_pend;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0) w = 1;
        end
        return w;
    endfunction

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        resp_ready = 1'b1;
        while (pending_work() && n < max) begin
            step();
            n++;
        end
        if (pending_work()) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout cycles=%0d limit=%0d", n, max);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_unit", 32'({unit_a, unit_b, unit_c}), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        for (int i = 0; i < N; i++) q[i].delete();
        m_pend  = 0;
        m_age   = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
        m_opnd  = 3'b000;
        prev_rv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int held;
        logic [7:0] tt;
        tt = 8'b1111_1001;

        do_reset();

        // Reset mid-WAIT drops the operation
        q[1].push_back(3'b011);
        resp_ready = 1'b1;
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        resp_ready = 1'b1;
        repeat (4) step();

        // Truth table through requester 0
        rsp_log.delete();
        for (int o = 0; o < 8; o++) q[0].push_back(3'(o));
        run_until_idle(200);
        chk("tt_count", 32'(rsp_log.size()), 32'd8);
        for (int o = 0; o < 8 && o < rsp_log.size(); o++) begin
            chk($sformatf("tt_%0d", o), 32'(rsp_log[o]), 32'(tt[o]));
        end

        // Round robin with all four held
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < N; i++) begin
            q[i].push_back(3'($urandom));
            q[i].push_back(3'($urandom));
        end
        resp_ready = 1'b1;
        n = 0;
        while (gnt_log.size() < 5 && n < 100) begin
            step();
            n++;
        end
        chk("rr_count", 32'(gnt_log.size()), 32'd5);
        if (gnt_log.size() >= 5) begin
            chk("rr_g0", 32'(gnt_log[0]), 32'd0);
            chk("rr_g1", 32'(gnt_log[1]), 32'd1);
            chk("rr_g2", 32'(gnt_log[2]), 32'd2);
            chk("rr_g3", 32'(gnt_log[3]), 32'd3);
            chk("rr_g4", 32'(gnt_log[4]), 32'd0);
        end
        run_until_idle(200);

        // Backpressure with another request waiting
        q[2].push_back(3'b010);
        q[3].push_back(3'b101);
        resp_ready = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin
            step();
            n++;
        end
        chk("bp_valid", 32'(resp_valid), 32'd1);
        held = 0;
        repeat (5) begin
            step();
            if (resp_valid) held++;
        end
        chk("bp_hold", 32'(held), 32'd5);
        run_until_idle(100);

        // Self-check error, sticky until reset
        corrupt = 1'b1;
        q[1].push_back(3'b100);
        run_until_idle(50);
        corrupt = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        q[2].push_back(3'b111);
        run_until_idle(50);
        chk("err_sticky", 32'(err), 32'd1);
        do_reset();

        // Pointer wrap and skip
        q[2].push_back(3'b001);
        run_until_idle(50);
        gnt_log.delete();
        q[0].push_back(3'b110);
        q[2].push_back(3'b000);
        run_until_idle(50);
        for (int i = 0; i < N; i++) q[i].push_back(3'($urandom));
        run_until_idle(100);
        chk("wrap_count", 32'(gnt_log.size()), 32'd6);
        if (gnt_log.size() >= 3) begin
            chk("wrap_g0", 32'(gnt_log[0]), 32'd0);
            chk("wrap_g1", 32'(gnt_log[1]), 32'd2);
            chk("wrap_g2", 32'(gnt_log[2]), 32'd3);
        end

        // Random traffic with random backpressure
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                q[$urandom_range(0, N-1)].push_back(3'($urandom));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        run_until_idle(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
